// File: rtl/fact_pkg.sv
// Shared types and defaults for the factorial job arbiter.
// The FSM encoding is exported as an enum; the top uses legacy logic constants mapped onto it.
package fact_pkg;

   localparam int DW_DEF      = 8;
   localparam int TIMEOUT_DEF = 1023;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LAUNCH    = 3'd1,
      WAIT_BUSY = 3'd2,
      RUN       = 3'd3,
      RESP      = 3'd4
   } state_e;

endpackage

// File: rtl/fact_job_arbiter_if.sv
// Bundle of requester, response and core-side signals around the job arbiter.
// slave = arbiter view, master = requesters plus the factorial core.
interface fact_job_arbiter_if #(parameter int DW = 8);

   logic          req0_valid;
   logic          req0_ready;
   logic [DW-1:0] req0_a;
   logic [DW-1:0] req0_b;
   logic          req1_valid;
   logic          req1_ready;
   logic [DW-1:0] req1_a;
   logic [DW-1:0] req1_b;

   logic          rsp0_valid;
   logic          rsp0_ready;
   logic [DW-1:0] rsp0_data;
   logic          rsp0_err;
   logic          rsp1_valid;
   logic          rsp1_ready;
   logic [DW-1:0] rsp1_data;
   logic          rsp1_err;

   logic          core_start;
   logic [DW-1:0] core_ina;
   logic [DW-1:0] core_inb;
   logic          core_busy;
   logic [DW-1:0] core_out;

   modport slave (
      input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
      input  rsp0_ready, rsp1_ready, core_busy, core_out,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_data, rsp0_err, rsp1_valid, rsp1_data, rsp1_err,
      output core_start, core_ina, core_inb
   );

   modport master (
      output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
      output rsp0_ready, rsp1_ready, core_busy, core_out,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_data, rsp0_err, rsp1_valid, rsp1_data, rsp1_err,
      input  core_start, core_ina, core_inb
   );

endinterface

// File: rtl/fact_job_arbiter_rr_arb2.sv
// Two-way round-robin selector; the caller owns the last_grant history bit.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic       grant_id,
   output logic       grant_valid
);

   always_comb begin
      grant_valid = |valid;
      grant_id    = 1'b0;
      if (&valid) begin
         grant_id = ~last_grant;
      end else begin
         grant_id = valid[1];
      end
   end

endmodule

// File: rtl/fact_job_arbiter.sv
// Shares one factorial core between two requesters: round-robin accept, one-cycle
// start pulse, busy tracking, watchdog abort and a per-requester response channel.
module fact_job_arbiter
   import fact_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TW      = 10
) (
   input  logic               clk,
   input  logic               reset,
   fact_job_arbiter_if.slave  bus
);

   localparam logic [2:0] ST_IDLE      = IDLE;
   localparam logic [2:0] ST_LAUNCH    = LAUNCH;
   localparam logic [2:0] ST_WAIT_BUSY = WAIT_BUSY;
   localparam logic [2:0] ST_RUN       = RUN;
   localparam logic [2:0] ST_RESP      = RESP;

   logic [2:0]    state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic          id_q, id_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [DW-1:0] result_q, result_d;
   logic          err_q, err_d;
   logic [TW-1:0] wdog_q, wdog_d;

   logic grant_id;
   logic grant_valid;
   logic accept;
   logic timeout_hit;
   logic rsp_ready_sel;

   rr_arb2 u_arb (
      .valid       ({bus.req1_valid, bus.req0_valid}),
      .last_grant  (last_grant_q),
      .grant_id    (grant_id),
      .grant_valid (grant_valid)
   );

   // Ready is masked while reset is asserted so nothing looks accepted during reset.
   assign accept        = (state_q == ST_IDLE) && grant_valid && reset;
   // The watchdog is cleared in LAUNCH, so hitting TIMEOUT-2 here lands RESP TIMEOUT cycles after LAUNCH.
   assign timeout_hit   = (wdog_q == TW'(TIMEOUT - 2));
   assign rsp_ready_sel = id_q ? bus.rsp1_ready : bus.rsp0_ready;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      a_d          = a_q;
      b_d          = b_q;
      result_d     = result_q;
      err_d        = err_q;
      wdog_d       = wdog_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               a_d          = grant_id ? bus.req1_a : bus.req0_a;
               b_d          = grant_id ? bus.req1_b : bus.req0_b;
               id_d         = grant_id;
               last_grant_d = grant_id;
               state_d      = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            wdog_d  = '0;
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            wdog_d = wdog_q + TW'(1);
            if (timeout_hit) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = ST_RESP;
            end else if (bus.core_busy) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            wdog_d = wdog_q + TW'(1);
            // A genuine completion wins over an abort landing on the same cycle.
            if (!bus.core_busy) begin
               result_d = bus.core_out;
               err_d    = 1'b0;
               state_d  = ST_RESP;
            end else if (timeout_hit) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready_sel) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         result_q     <= '0;
         err_q        <= 1'b0;
         wdog_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         a_q          <= a_d;
         b_q          <= b_d;
         result_q     <= result_d;
         err_q        <= err_d;
         wdog_q       <= wdog_d;
      end
   end

   assign bus.req0_ready = accept && !grant_id;
   assign bus.req1_ready = accept &&  grant_id;
   assign bus.core_start = (state_q == ST_LAUNCH);
   assign bus.core_ina   = a_q;
   assign bus.core_inb   = b_q;

   // The idle response channel keeps data and err at zero as well as valid.
   assign bus.rsp0_valid = (state_q == ST_RESP) && !id_q;
   assign bus.rsp1_valid = (state_q == ST_RESP) &&  id_q;
   assign bus.rsp0_data  = bus.rsp0_valid ? result_q : '0;
   assign bus.rsp1_data  = bus.rsp1_valid ? result_q : '0;
   assign bus.rsp0_err   = bus.rsp0_valid && err_q;
   assign bus.rsp1_err   = bus.rsp1_valid && err_q;

endmodule

// File: tb/tb_fact_job_arbiter.sv
// Directed bench: a behavioural core model (busy 2 cycles after start, 6 cycles long,
// optionally stuck high) drives one arbiter; a second instance sees a core that never goes busy.
module tb_fact_job_arbiter;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   start_cnt = 0;

   logic [7:0] ph;
   logic       stuck_mode;
   logic [7:0] model_out;

   fact_job_arbiter_if #(.DW(8)) tif  ();
   fact_job_arbiter_if #(.DW(8)) tif8 ();

   fact_job_arbiter #(.DW(8), .TIMEOUT(20), .TW(10)) u_dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (tif)
   );

   fact_job_arbiter #(.DW(8), .TIMEOUT(8), .TW(4)) u_dut8 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (tif8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tif.core_start) start_cnt <= start_cnt + 1;
   end

   // ph counts cycles since the start pulse; busy covers ph 2..7 (or 2.. forever when stuck).
   always @(posedge clk) begin
      if (!rst_n) begin
         ph <= 8'd0;
      end else if (tif.core_start) begin
         ph <= 8'd1;
      end else if (ph != 8'd0) begin
         if (!stuck_mode && ph >= 8'd8) ph <= 8'd0;
         else if (ph < 8'd200)          ph <= ph + 8'd1;
      end
   end

   assign tif.core_busy  = stuck_mode ? (ph >= 8'd2) : (ph >= 8'd2 && ph <= 8'd7);
   assign tif.core_out   = model_out;
   assign tif8.core_busy = 1'b0;
   assign tif8.core_out  = 8'h55;

   task automatic init_inputs();
      tif.req0_valid = 0; tif.req0_a = 0; tif.req0_b = 0;
      tif.req1_valid = 0; tif.req1_a = 0; tif.req1_b = 0;
      tif.rsp0_ready = 0; tif.rsp1_ready = 0;
      tif8.req0_valid = 0; tif8.req0_a = 0; tif8.req0_b = 0;
      tif8.req1_valid = 0; tif8.req1_a = 0; tif8.req1_b = 0;
      tif8.rsp0_ready = 0; tif8.rsp1_ready = 0;
      stuck_mode = 0; model_out = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      repeat (3) @(negedge clk);
   endtask

   // Polls the chosen channel; at_cyc = cyc of first rsp_valid, -1 if none within limit.
   task automatic wait_rsp(input int ch, input int limit, output int at_cyc, output bit other_seen);
      at_cyc = -1;
      other_seen = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk); #1;
         if ((ch == 0 && tif.rsp1_valid) || (ch == 1 && tif.rsp0_valid)) other_seen = 1;
         if ((ch == 0 && tif.rsp0_valid) || (ch == 1 && tif.rsp1_valid)) begin
            at_cyc = cyc;
            return;
         end
      end
   endtask

   task automatic rsp_take(input int ch);
      if (ch == 0) tif.rsp0_ready = 1; else tif.rsp1_ready = 1;
      @(negedge clk);
      tif.rsp0_ready = 0; tif.rsp1_ready = 0;
      #1;
   endtask

   task automatic test_reset();
      init_inputs();
      rst_n = 0;
      tif.req0_valid = 1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (tif.req0_ready !== 1'b0) begin errors++; $display("FAIL rst_req0_ready: got %b expected 0", tif.req0_ready); end
      checks++; if (tif.rsp0_valid !== 1'b0 || tif.rsp1_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b%b expected 00", tif.rsp1_valid, tif.rsp0_valid); end
      checks++; if (tif.core_start !== 1'b0) begin errors++; $display("FAIL rst_core_start: got %b expected 0", tif.core_start); end
      checks++; if (tif.core_ina !== 8'd0 || tif.core_inb !== 8'd0) begin errors++; $display("FAIL rst_core_in: got %0d/%0d expected 0/0", tif.core_ina, tif.core_inb); end
      tif.req0_valid = 0;
      $display("reset: outputs sampled while reset asserted");
   endtask

   task automatic test_basic();
      int t, at, s0; bit oth;
      do_reset();
      rst_n = 1; tif.req0_valid = 1; tif.req0_a = 5; tif.req0_b = 0; model_out = 120;
      #1;
      checks++; if (tif.req0_ready !== 1'b1) begin errors++; $display("FAIL basic_req0_ready: got %b expected 1", tif.req0_ready); end
      checks++; if (tif.req1_ready !== 1'b0) begin errors++; $display("FAIL basic_req1_ready: got %b expected 0", tif.req1_ready); end
      t = cyc; s0 = start_cnt;
      @(negedge clk); tif.req0_valid = 0; #1;
      checks++; if (tif.core_start !== 1'b1) begin errors++; $display("FAIL basic_start_t1: got %b expected 1", tif.core_start); end
      checks++; if (tif.core_ina !== 8'd5) begin errors++; $display("FAIL basic_core_ina: got %0d expected 5", tif.core_ina); end
      @(negedge clk); #1;
      checks++; if (tif.core_start !== 1'b0) begin errors++; $display("FAIL basic_start_t2: got %b expected 0", tif.core_start); end
      wait_rsp(0, 30, at, oth);
      checks++; if (at - t !== 10) begin errors++; $display("FAIL basic_latency: got %0d expected 10", at - t); end
      checks++; if (tif.rsp0_data !== 8'd120 || tif.rsp0_err !== 1'b0) begin errors++; $display("FAIL basic_data: got %0d err %b expected 120 err 0", tif.rsp0_data, tif.rsp0_err); end
      checks++; if (oth !== 1'b0) begin errors++; $display("FAIL basic_rsp1_quiet: got %b expected 0", oth); end
      checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL basic_start_count: got %0d expected 1", start_cnt - s0); end
      $display("job req0 a=5 b=0 -> data=%0d err=%b latency=%0d", tif.rsp0_data, tif.rsp0_err, at - t);
      rsp_take(0);
      checks++; if (tif.rsp0_valid !== 1'b0) begin errors++; $display("FAIL basic_rsp_drop: got %b expected 0", tif.rsp0_valid); end
   endtask

   task automatic test_round_robin();
      int t, at; bit oth;
      do_reset();
      rst_n = 1; model_out = 6;
      tif.req0_valid = 1; tif.req0_a = 3; tif.req1_valid = 1; tif.req1_a = 4;
      #1;
      checks++; if (tif.req0_ready !== 1'b1 || tif.req1_ready !== 1'b0) begin errors++; $display("FAIL rr_first: got %b%b expected 01", tif.req1_ready, tif.req0_ready); end
      @(negedge clk); tif.req0_valid = 0; #1;
      checks++; if (tif.req1_ready !== 1'b0) begin errors++; $display("FAIL rr_busy_ready: got %b expected 0", tif.req1_ready); end
      wait_rsp(0, 30, at, oth);
      checks++; if (tif.rsp0_data !== 8'd6) begin errors++; $display("FAIL rr_data0: got %0d expected 6", tif.rsp0_data); end
      $display("job req0 a=3 -> data=%0d err=%b", tif.rsp0_data, tif.rsp0_err);
      model_out = 24;
      rsp_take(0);
      checks++; if (tif.req1_ready !== 1'b1) begin errors++; $display("FAIL rr_second: got %b expected 1", tif.req1_ready); end
      t = cyc;
      @(negedge clk); tif.req1_valid = 0;
      wait_rsp(1, 30, at, oth);
      checks++; if (tif.rsp1_data !== 8'd24 || at - t !== 10) begin errors++; $display("FAIL rr_data1: got %0d lat %0d expected 24 lat 10", tif.rsp1_data, at - t); end
      checks++; if (oth !== 1'b0) begin errors++; $display("FAIL rr_rsp0_quiet: got %b expected 0", oth); end
      $display("job req1 a=4 -> data=%0d err=%b", tif.rsp1_data, tif.rsp1_err);
      model_out = 2;
      rsp_take(1);
      tif.req0_valid = 1; tif.req0_a = 2; tif.req1_valid = 1; tif.req1_a = 3;
      #1;
      checks++; if (tif.req0_ready !== 1'b1 || tif.req1_ready !== 1'b0) begin errors++; $display("FAIL rr_third: got %b%b expected 01", tif.req1_ready, tif.req0_ready); end
      @(negedge clk); tif.req0_valid = 0; tif.req1_valid = 0;
      wait_rsp(0, 30, at, oth);
      checks++; if (tif.rsp0_data !== 8'd2) begin errors++; $display("FAIL rr_data2: got %0d expected 2", tif.rsp0_data); end
      $display("job req0 a=2 -> data=%0d err=%b", tif.rsp0_data, tif.rsp0_err);
      rsp_take(0);
   endtask

   task automatic test_timeout();
      int t, at, s0; bit oth;
      stuck_mode = 1; model_out = 99;
      tif.req0_valid = 1; tif.req0_a = 7; #1;
      checks++; if (tif.req0_ready !== 1'b1) begin errors++; $display("FAIL to_ready: got %b expected 1", tif.req0_ready); end
      t = cyc; s0 = start_cnt;
      @(negedge clk); tif.req0_valid = 0;
      wait_rsp(0, 40, at, oth);
      checks++; if (at - (t + 1) !== 20) begin errors++; $display("FAIL to_latency: got %0d expected 20", at - (t + 1)); end
      checks++; if (tif.rsp0_err !== 1'b1 || tif.rsp0_data !== 8'd0) begin errors++; $display("FAIL to_err: got err %b data %0d expected err 1 data 0", tif.rsp0_err, tif.rsp0_data); end
      checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL to_start_count: got %0d expected 1", start_cnt - s0); end
      $display("job req0 a=7 stuck core -> data=%0d err=%b", tif.rsp0_data, tif.rsp0_err);
      rsp_take(0);
      stuck_mode = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int at; bit oth; bit stable_ok; bit quiet_ok;
      model_out = 24;
      tif.req0_valid = 1; tif.req0_a = 4; #1;
      checks++; if (tif.req0_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %b expected 1", tif.req0_ready); end
      @(negedge clk); tif.req0_valid = 0; tif.req1_valid = 1; tif.req1_a = 1;
      wait_rsp(0, 30, at, oth);
      model_out = 1;
      stable_ok = 1; quiet_ok = 1;
      for (int i = 0; i < 10; i++) begin
         if (tif.rsp0_valid !== 1'b1 || tif.rsp0_data !== 8'd24) stable_ok = 0;
         if (tif.req1_ready !== 1'b0) quiet_ok = 0;
         @(negedge clk); #1;
      end
      checks++; if (stable_ok !== 1'b1) begin errors++; $display("FAIL b2b_stable: got data %0d valid %b expected 24 1", tif.rsp0_data, tif.rsp0_valid); end
      checks++; if (quiet_ok !== 1'b1) begin errors++; $display("FAIL b2b_req1_held: got ready seen expected 0"); end
      $display("job req0 a=4 stalled 10 cycles -> data=%0d err=%b", tif.rsp0_data, tif.rsp0_err);
      rsp_take(0);
      checks++; if (tif.req1_ready !== 1'b1 || tif.req0_ready !== 1'b0) begin errors++; $display("FAIL b2b_req1_accept: got %b%b expected 10", tif.req1_ready, tif.req0_ready); end
      @(negedge clk); tif.req1_valid = 0;
      wait_rsp(1, 30, at, oth);
      checks++; if (tif.rsp1_data !== 8'd1) begin errors++; $display("FAIL b2b_data1: got %0d expected 1", tif.rsp1_data); end
      $display("job req1 a=1 -> data=%0d err=%b", tif.rsp1_data, tif.rsp1_err);
      rsp_take(1);
   endtask

   task automatic test_reset_mid_run();
      int t, at; bit oth;
      model_out = 77;
      tif.req0_valid = 1; tif.req0_a = 6; tif.req0_b = 2;
      @(negedge clk); tif.req0_valid = 0;
      repeat (4) @(negedge clk);
      rst_n = 0;
      @(negedge clk); #1;
      checks++; if (tif.rsp0_valid !== 1'b0 || tif.rsp1_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid: got %b%b expected 00", tif.rsp1_valid, tif.rsp0_valid); end
      checks++; if (tif.core_start !== 1'b0 || tif.core_ina !== 8'd0 || tif.core_inb !== 8'd0) begin errors++; $display("FAIL mid_core: got start %b ina %0d inb %0d expected 0 0 0", tif.core_start, tif.core_ina, tif.core_inb); end
      checks++; if (tif.rsp0_data !== 8'd0 || tif.rsp0_err !== 1'b0) begin errors++; $display("FAIL mid_rsp_data: got %0d err %b expected 0 0", tif.rsp0_data, tif.rsp0_err); end
      @(negedge clk); rst_n = 1;
      wait_rsp(0, 15, at, oth);
      checks++; if (at !== -1) begin errors++; $display("FAIL mid_no_rsp: got rsp at cycle %0d expected none", at); end
      model_out = 6;
      @(negedge clk);
      tif.req0_valid = 1; tif.req0_a = 3; tif.req0_b = 0; #1;
      checks++; if (tif.req0_ready !== 1'b1) begin errors++; $display("FAIL mid_reaccept: got %b expected 1", tif.req0_ready); end
      t = cyc;
      @(negedge clk); tif.req0_valid = 0;
      wait_rsp(0, 30, at, oth);
      checks++; if (tif.rsp0_data !== 8'd6 || at - t !== 10) begin errors++; $display("FAIL mid_after: got %0d lat %0d expected 6 lat 10", tif.rsp0_data, at - t); end
      $display("job req0 a=3 after mid-run reset -> data=%0d err=%b", tif.rsp0_data, tif.rsp0_err);
      rsp_take(0);
   endtask

   task automatic test_never_busy();
      int t, at;
      at = -1;
      tif8.req0_valid = 1; tif8.req0_a = 9; #1;
      checks++; if (tif8.req0_ready !== 1'b1) begin errors++; $display("FAIL nb_ready: got %b expected 1", tif8.req0_ready); end
      t = cyc;
      @(negedge clk); tif8.req0_valid = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (tif8.rsp0_valid) begin at = cyc; break; end
      end
      checks++; if (at - (t + 1) !== 8) begin errors++; $display("FAIL nb_latency: got %0d expected 8", at - (t + 1)); end
      checks++; if (tif8.rsp0_err !== 1'b1 || tif8.rsp0_data !== 8'd0) begin errors++; $display("FAIL nb_err: got err %b data %0d expected err 1 data 0", tif8.rsp0_err, tif8.rsp0_data); end
      $display("job req0 a=9 idle core -> data=%0d err=%b", tif8.rsp0_data, tif8.rsp0_err);
      tif8.rsp0_ready = 1;
      @(negedge clk); tif8.rsp0_ready = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_timeout();
      test_back_to_back();
      test_reset_mid_run();
      test_never_busy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
